// File: rtl/pid_seq_if.sv
// pid_seq_if: sensor-side samples and command
// outputs of the line-follower speed sequencer.
interface pid_seq_if;
  logic        go;
  logic        line_present;
  logic [11:0] error;
  logic        error_vld;
  logic [10:0] err_sat;
  logic        err_vld;
  logic        moving;
  logic [10:0] frwrd_spd;

  modport master (
    output go, line_present, error, error_vld,
    input  err_sat, err_vld, moving, frwrd_spd
  );

  modport slave (
    input  go, line_present, error, error_vld,
    output err_sat, err_vld, moving, frwrd_spd
  );
endinterface

// File: rtl/pid_seq.sv
// pid_seq: steering-error saturation plus the
// forward-speed ramp / line-loss sequencer.
module pid_seq #(
  parameter logic [10:0] RAMP_STEP = 11'h040,
  parameter logic [10:0] MAX_SPD   = 11'h300,
  parameter int unsigned LOST_CYC  = 4
) (
  input  logic     clk,
  input  logic     rst_n,
  pid_seq_if.slave bus
);

  typedef enum logic [1:0] {
    IDLE,
    RAMP,
    RUN,
    LOST
  } state_e;

  localparam logic [2:0] LOST_N = 3'(LOST_CYC);

  state_e      state_q, state_d;
  logic [10:0] spd_q, spd_d;
  logic [2:0]  cnt_q, cnt_d, cnt_smp;
  logic        moving_q, moving_d;
  logic [10:0] sat_q, sat_d;
  logic        vld_q;

  logic        smp;
  logic        lp;
  logic        hit;
  logic [11:0] up;
  logic [11:0] dn;
  logic [10:0] ramp_v;
  logic [10:0] fall_v;

  assign smp = bus.error_vld;
  assign lp  = bus.line_present;

  // Clamp the 12-bit signed error into 11 bits
  always_comb begin
    sat_d = bus.error[10:0];
    unique case (1'b1)
      (!bus.error[11] && bus.error[10]):
        sat_d = 11'h3FF;
      (bus.error[11] && !bus.error[10]):
        sat_d = 11'h400;
      default: ;
    endcase
  end

  // Saturated error register and its valid pulse
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sat_q <= '0;
      vld_q <= 1'b0;
    end else begin
      vld_q <= smp;
      if (smp) sat_q <= sat_d;
    end
  end

  // Speed arithmetic, widened to catch carry/borrow
  always_comb begin
    up      = {1'b0, spd_q} + {1'b0, RAMP_STEP};
    dn      = {1'b0, spd_q} - {1'b0, RAMP_STEP};
    ramp_v  = (up >= {1'b0, MAX_SPD}) ?
              MAX_SPD : up[10:0];
    fall_v  = dn[11] ? 11'h000 : dn[10:0];
    cnt_smp = lp ? 3'd0 :
              (cnt_q == LOST_N) ? cnt_q :
              cnt_q + 3'd1;
    hit     = !lp && (cnt_smp == LOST_N);
  end

  // Sequencer next state; go low wins over all
  always_comb begin
    state_d = state_q;
    spd_d   = spd_q;
    cnt_d   = cnt_q;
    unique case (state_q)
      IDLE: begin
        spd_d = '0;
        cnt_d = '0;
        if (lp) state_d = RAMP;
      end
      RAMP: begin
        if (smp) begin
          cnt_d = cnt_smp;
          if (hit) begin
            state_d = LOST;
          end else begin
            spd_d = ramp_v;
            if (ramp_v == MAX_SPD) state_d = RUN;
          end
        end
      end
      RUN: begin
        spd_d = MAX_SPD;
        if (smp) begin
          cnt_d = cnt_smp;
          if (hit) state_d = LOST;
        end
      end
      LOST: begin
        if (smp) begin
          cnt_d = cnt_smp;
          if (lp) begin
            state_d = RAMP;
          end else begin
            spd_d = fall_v;
            if (fall_v == '0) state_d = IDLE;
          end
        end
      end
      default: state_d = IDLE;
    endcase
    if (!bus.go) begin
      state_d = IDLE;
      spd_d   = '0;
      cnt_d   = '0;
    end
    moving_d = (state_d != IDLE);
  end

  // Sequencer state, speed, loss count, motion flag
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= IDLE;
      spd_q    <= '0;
      cnt_q    <= '0;
      moving_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      spd_q    <= spd_d;
      cnt_q    <= cnt_d;
      moving_q <= moving_d;
    end
  end

  assign bus.err_sat   = sat_q;
  assign bus.err_vld   = vld_q;
  assign bus.moving    = moving_q;
  assign bus.frwrd_spd = spd_q;

endmodule

// File: doc/pid_seq.md
PID_SEQ -- requirements
Module: pid_seq

Interface
REQ-001 Parameter: RAMP_STEP, 11'h040, unsigned forward-speed increment/decrement per sample.
REQ-002 Parameter: MAX_SPD, 11'h300, unsigned forward-speed ceiling reached at end of ramp.
REQ-003 Parameter: LOST_CYC, 4, consecutive line-absent samples required to declare line lost (range 1..7).
REQ-004 clk  input  1  system clock; all state updates on rising edge.
REQ-005 rst_n  input  1  asynchronous active-low reset.
REQ-006 go  input  1  run enable from command logic; low forces stop.
REQ-007 line_present  input  1  line sensor reports line under robot.
REQ-008 error  input  12  signed raw steering error from sensor front end.
REQ-009 error_vld  input  1  one-cycle pulse; error and line_present valid (a "sample").
REQ-010 err_sat  output  11  signed saturated error to PID terms.
REQ-011 err_vld  output  1  one-cycle pulse; err_sat updated this cycle.
REQ-012 moving  output  1  robot in motion; low clears integrator downstream.
REQ-013 frwrd_spd  output  11  unsigned forward-speed command.

Function
REQ-014 Saturation on sample edge: error > 12'sh3FF -> 11'h3FF; error < -12'sh400 -> 11'h400; else error[10:0].
REQ-015 err_sat registered, held between samples; err_vld high exactly one cycle after each error_vld, otherwise low.
REQ-016 Back-to-back error_vld pulses SHALL yield back-to-back err_vld pulses, no sample dropped.
REQ-017 States: IDLE, RAMP, RUN, LOST; encoded one register, no other reachable states.
REQ-018 lost_cnt (3 bits): on sample with line_present=0, increment saturating at LOST_CYC; on sample with line_present=1, clear; cleared in IDLE.
REQ-019 IDLE: frwrd_spd=0, moving=0; on edge with go=1 and line_present=1 -> RAMP (no sample required).
REQ-020 RAMP: each sample, frwrd_spd = min(frwrd_spd+RAMP_STEP, MAX_SPD) using 12-bit intermediate; result == MAX_SPD -> RUN.
REQ-021 RUN: frwrd_spd held at MAX_SPD.
REQ-022 RAMP or RUN: sample on which lost_cnt reaches LOST_CYC -> LOST; that sample does not increment speed.
REQ-023 LOST: each sample with line_present=0, frwrd_spd = max(frwrd_spd-RAMP_STEP, 0); result 0 -> IDLE.
REQ-024 LOST: sample with line_present=1 -> RAMP, speed unchanged on that sample.
REQ-025 moving registered: 1 in RAMP, RUN, LOST; 0 in IDLE; updates with state.
REQ-026 go=0 at any edge, any state: next state IDLE, frwrd_spd=0, lost_cnt=0, moving=0; overrides all simultaneous events.
REQ-027 go=0 does not gate the saturation path; err_sat/err_vld keep tracking samples in all states.
REQ-028 No combinational path from any input to any output.

Reset
REQ-029 rst_n low asynchronously forces IDLE, err_sat=0, err_vld=0, moving=0, frwrd_spd=0, lost_cnt=0, including mid-ramp or mid-LOST.
REQ-030 First sample after rst_n deasserts is processed normally.

Verification
REQ-031 Reset: rst_n=0 with go=1, error_vld pulsing -> all outputs 0; release, no sample -> IDLE.
REQ-032 Saturation: error 12'h7FF, 12'h800, 12'h0F0, 12'hF10 -> err_sat 0x3FF, 0x400, 0x0F0, 0x710, each with one-cycle err_vld one cycle after error_vld.
REQ-033 Ramp: go=1, line_present=1, sample every 4 clocks -> moving=1 next cycle; frwrd_spd 0x040, 0x080, ... 0x300 after 12 samples; RUN, holds 0x300.
REQ-034 Line loss: in RUN, line_present=0 -> 3 samples speed 0x300; 4th -> LOST; following samples 0x2C0, 0x280; line_present=1 sample -> RAMP, climbs back to 0x300.
REQ-035 Full loss: line_present held 0 in LOST -> speed reaches 0 after 12 decrements, IDLE, moving=0.
REQ-036 Abort: go=0 at frwrd_spd=0x180 coinciding with a sample -> next cycle frwrd_spd=0, moving=0, IDLE; err_vld still pulses.
